systolic_ctrl: RTL and testbench

Sequencer for an N x N systolic array of FP8 E4M3 MAC processing elements that produce BF16 accumulators. It accepts one matrix-multiply job of depth K and streams A columns and B rows into the array edges with the diagonal skew. It then clears, feeds, drains and snapshots the array, and streams the N x N BF16 result out row by row. It sits between the operand buffers / host FSM and the PE array.

---
 rtl/tpu_pkg.sv | 22 ++
 rtl/systolic_ctrl_if.sv | 41 ++++
 rtl/skew_line.sv | 43 ++++
 rtl/systolic_ctrl.sv | 150 +++++++++++++++
 tb/tb_systolic_ctrl.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tpu_pkg.sv
// Shared definitions for the systolic-array sequencer: element widths,
// controller state encoding and the drain-length helper.
package tpu_pkg;

  localparam int FP8_W  = 8;
  localparam int BF16_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_FEED    = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_OUT     = 3'd5
  } state_e;

  // Cycles of zero input needed to push the last operands through PE(N-1,N-1).
  function automatic int drain_len(input int n);
    return 2 * n - 1;
  endfunction

endpackage

// File: rtl/systolic_ctrl_if.sv
// Bundle of job, operand, array-edge and result signals around the sequencer.
// The controller uses the slave view; the environment (buffers, host, array)
// uses the master view.
interface systolic_ctrl_if
  import tpu_pkg::*;
#(
  parameter int N  = 2,
  parameter int KW = 8
);

  logic                      start;
  logic [KW-1:0]             k_len;
  logic                      busy;
  logic                      a_valid;
  logic [N*FP8_W-1:0]        a_data;
  logic                      a_ready;
  logic                      b_valid;
  logic [N*FP8_W-1:0]        b_data;
  logic                      b_ready;
  logic [N*FP8_W-1:0]        arr_a;
  logic [N*FP8_W-1:0]        arr_b;
  logic                      arr_clear;
  logic [N*N*BF16_W-1:0]     arr_c;
  logic                      res_valid;
  logic                      res_ready;
  logic [N*BF16_W-1:0]       res_data;
  logic                      res_last;

  modport master (
    output start, k_len, a_valid, a_data, b_valid, b_data, arr_c, res_ready,
    input  busy, a_ready, b_ready, arr_a, arr_b, arr_clear, res_valid,
           res_data, res_last
  );

  modport slave (
    input  start, k_len, a_valid, a_data, b_valid, b_data, arr_c, res_ready,
    output busy, a_ready, b_ready, arr_a, arr_b, arr_clear, res_valid,
           res_data, res_last
  );

endinterface

// File: rtl/skew_line.sv
// DEPTH-stage byte delay line used to skew one array-edge lane.
// DEPTH = 0 is a plain wire so lane 0 reaches the array in the same cycle.
module skew_line
  import tpu_pkg::*;
#(
  parameter int DEPTH = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [FP8_W-1:0] din,
  output logic [FP8_W-1:0] dout
);

  if (DEPTH == 0) begin : g_pass
    logic unused_ok;
    assign unused_ok = &{1'b0, clk, rst_n};
    assign dout      = din;
  end else begin : g_shift
    logic [DEPTH-1:0][FP8_W-1:0] stage_q;
    logic [DEPTH-1:0][FP8_W-1:0] stage_d;

    // Shift the new byte in at stage 0, every other stage takes its neighbour.
    always_comb begin
      stage_d    = stage_q;
      stage_d[0] = din;
      for (int s = 1; s < DEPTH; s++) begin
        stage_d[s] = stage_q[s-1];
      end
    end

    // Delay-line storage, cleared by reset so a killed job leaves no residue.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stage_q <= '0;
      end else begin
        stage_q <= stage_d;
      end
    end

    assign dout = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/systolic_ctrl.sv
// Job sequencer for an N x N FP8 -> BF16 systolic array: clears the array,
// streams skewed A columns / B rows in, drains, snapshots the accumulators
// and returns the result matrix one row per handshake.
module systolic_ctrl
  import tpu_pkg::*;
#(
  parameter int N  = 2,
  parameter int KW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  systolic_ctrl_if.slave bus
);

  localparam int DRAIN_LEN = drain_len(N);
  localparam int DCNT_W    = $clog2(DRAIN_LEN + 1);
  localparam int ROW_W     = (N > 1) ? $clog2(N) : 1;
  localparam int ROW_BITS  = N * BF16_W;
  localparam int RES_W     = N * N * BF16_W;

  state_e             state_q, state_d;
  logic [KW-1:0]      k_len_q, k_len_d;
  logic [KW-1:0]      k_cnt_q, k_cnt_d;
  logic [DCNT_W-1:0]  drain_q, drain_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [RES_W-1:0]   res_q, res_d;
  logic               busy_q, busy_d;
  logic               clear_q, clear_d;
  logic               res_valid_q, res_valid_d;
  logic               res_last_q, res_last_d;

  logic                        beat;
  logic [N*FP8_W-1:0]          a_sel, b_sel;
  logic [N-1:0][FP8_W-1:0]     a_skew, b_skew;

  // A and B are consumed jointly; any cycle without a beat feeds zeros,
  // which add nothing to the accumulators.
  assign beat        = (state_q == ST_FEED) && bus.a_valid && bus.b_valid;
  assign bus.a_ready = beat;
  assign bus.b_ready = beat;
  assign a_sel       = beat ? bus.a_data : '0;
  assign b_sel       = beat ? bus.b_data : '0;

  for (genvar gi = 0; gi < N; gi++) begin : g_skew
    skew_line #(.DEPTH(gi)) u_a_skew (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (a_sel[gi*FP8_W +: FP8_W]),
      .dout (a_skew[gi])
    );
    skew_line #(.DEPTH(gi)) u_b_skew (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (b_sel[gi*FP8_W +: FP8_W]),
      .dout (b_skew[gi])
    );
  end

  assign bus.arr_a     = a_skew;
  assign bus.arr_b     = b_skew;
  assign bus.arr_clear = clear_q;
  assign bus.busy      = busy_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_last  = res_last_q;
  assign bus.res_data  = res_q[row_q*ROW_BITS +: ROW_BITS];

  // Next-state, counters, result snapshot and the registered status outputs.
  always_comb begin
    state_d = state_q;
    k_len_d = k_len_q;
    k_cnt_d = k_cnt_q;
    drain_d = drain_q;
    row_d   = row_q;
    res_d   = res_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          k_len_d = bus.k_len;
          k_cnt_d = '0;
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        drain_d = '0;
        state_d = (k_len_q == '0) ? ST_DRAIN : ST_FEED;
      end
      ST_FEED: begin
        if (beat) begin
          k_cnt_d = k_cnt_q + KW'(1);
          if (k_cnt_d == k_len_q) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        drain_d = drain_q + DCNT_W'(1);
        if (drain_q == DCNT_W'(DRAIN_LEN - 1)) begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        res_d   = bus.arr_c;
        row_d   = '0;
        state_d = ST_OUT;
      end
      ST_OUT: begin
        if (bus.res_ready) begin
          if (row_q == ROW_W'(N - 1)) begin
            state_d = ST_IDLE;
          end else begin
            row_d = row_q + ROW_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d      = (state_d != ST_IDLE);
    clear_d     = (state_d == ST_CLEAR);
    res_valid_d = (state_d == ST_OUT);
    res_last_d  = (state_d == ST_OUT) && (row_d == ROW_W'(N - 1));
  end

  // Controller state; reset abandons any job in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      k_len_q     <= '0;
      k_cnt_q     <= '0;
      drain_q     <= '0;
      row_q       <= '0;
      res_q       <= '0;
      busy_q      <= 1'b0;
      clear_q     <= 1'b0;
      res_valid_q <= 1'b0;
      res_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_len_q     <= k_len_d;
      k_cnt_q     <= k_cnt_d;
      drain_q     <= drain_d;
      row_q       <= row_d;
      res_q       <= res_d;
      busy_q      <= busy_d;
      clear_q     <= clear_d;
      res_valid_q <= res_valid_d;
      res_last_q  <= res_last_d;
    end
  end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Bench for systolic_ctrl: a behavioural PE-array model closes the loop,
// table vectors cover the directed jobs, random jobs are checked against a
// plain matrix-product reference with the expected latency formula.
module tb_systolic_ctrl;

  localparam int N    = 2;
  localparam int KW   = 8;
  localparam int KMAX = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  systolic_ctrl_if #(.N(N), .KW(KW)) bus ();
  systolic_ctrl #(.N(N), .KW(KW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic real pow2(input int x);
    real r;
    r = 1.0;
    if (x >= 0) repeat (x) r = r * 2.0;
    else repeat (-x) r = r / 2.0;
    return r;
  endfunction

  function automatic real fp8_to_real(input logic [7:0] v);
    real m, s;
    int e;
    e = int'(v[6:3]);
    m = real'(v[2:0]) / 8.0;
    if (e == 0) s = m * pow2(-6);
    else s = (1.0 + m) * pow2(e - 7);
    return v[7] ? -s : s;
  endfunction

  function automatic logic [15:0] real_to_bf16(input real x);
    logic [63:0] b;
    int e;
    if (x == 0.0) return 16'h0000;
    b = $realtobits(x);
    e = int'(b[62:52]) - 1023 + 127;
    return {b[63], e[7:0], b[51:45]};
  endfunction

  // ---------------- PE array model (environment) ----------------
  real        acc [N][N] = '{default: 0.0};
  logic [7:0] pa  [N][N] = '{default: 8'h00};
  logic [7:0] pb  [N][N] = '{default: 8'h00};

  function automatic logic [7:0] pe_a(input int i, input int j);
    if (j == 0) return bus.arr_a[i*8 +: 8];
    return pa[i][j-1];
  endfunction

  function automatic logic [7:0] pe_b(input int i, input int j);
    if (i == 0) return bus.arr_b[j*8 +: 8];
    return pb[i-1][j];
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        pa[i][j] <= pe_a(i, j);
        pb[i][j] <= pe_b(i, j);
        if (bus.arr_clear) acc[i][j] <= 0.0;
        else acc[i][j] <= acc[i][j] + fp8_to_real(pe_a(i, j)) * fp8_to_real(pe_b(i, j));
      end
    end
  end

  always_comb begin
    bus.arr_c = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        bus.arr_c[(i*N+j)*16 +: 16] = real_to_bf16(acc[i][j]);
  end

  // ---------------- job data, reference model ----------------
  logic [7:0]  a_mat [N][KMAX];
  logic [7:0]  b_mat [KMAX][N];
  int          stall_pat [KMAX];
  logic [15:0] got [N][N];
  logic [7:0]  pool [7] = '{8'h00, 8'h38, 8'h40, 8'hB8, 8'h30, 8'h44, 8'hC0};

  function automatic logic [15:0] ref_c(input int r, input int j, input int k);
    real s;
    s = 0.0;
    for (int kk = 0; kk < k; kk++) s = s + fp8_to_real(a_mat[r][kk]) * fp8_to_real(b_mat[kk][j]);
    return real_to_bf16(s);
  endfunction

  typedef struct {
    int               k;
    int               stall;
    int               hold;
    logic [1:0][15:0] a_col;  // a_col[k] = {A[1][k], A[0][k]}
    logic [1:0][15:0] b_row;  // b_row[k] = {B[k][1], B[k][0]}
    logic [1:0][31:0] c_row;  // c_row[r] = {C[r][1], C[r][0]}
    int               lat;
  } vec_t;

  function automatic vec_t mk(input int k, input int stall, input int hold,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [63:0] c, input int lat);
    vec_t v;
    v.k = k; v.stall = stall; v.hold = hold;
    v.a_col = a; v.b_row = b; v.c_row = c; v.lat = lat;
    return v;
  endfunction

  task automatic load_vec(input vec_t v);
    for (int kk = 0; kk < KMAX; kk++) stall_pat[kk] = 0;
    stall_pat[1] = v.stall;
    for (int kk = 0; kk < 2; kk++) begin
      for (int i = 0; i < N; i++) a_mat[i][kk] = v.a_col[kk][i*8 +: 8];
      for (int j = 0; j < N; j++) b_mat[kk][j] = v.b_row[kk][j*8 +: 8];
    end
  endtask

  // Runs one whole job; fills got[][] and returns start-to-res_valid latency.
  task automatic run_job(input int k, input int hold, output int lat);
    int kb, stall_left, clr_cnt, cyc, gate_viol, stab_viol;
    logic [N*16-1:0] held;
    kb = 0; stall_left = 0; clr_cnt = 0; cyc = 0; gate_viol = 0; stab_viol = 0; lat = -1;
    @(negedge clk);
    bus.start = 1'b1; bus.k_len = KW'(k); bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    while (cyc < 300 && lat < 0) begin
      if (bus.res_valid) begin
        lat = cyc;
      end else begin
        if (bus.arr_clear) clr_cnt++;
        if (kb < k) begin
          bus.a_valid = (stall_left == 0);
          bus.b_valid = 1'b1;
          for (int i = 0; i < N; i++) bus.a_data[i*8 +: 8] = a_mat[i][kb];
          for (int j = 0; j < N; j++) bus.b_data[j*8 +: 8] = b_mat[kb][j];
        end else begin
          bus.a_valid = 1'b0; bus.b_valid = 1'b0; bus.a_data = '0; bus.b_data = '0;
        end
        #1;
        if (bus.a_ready !== bus.b_ready) gate_viol++;
        if (bus.a_ready && !(bus.a_valid && bus.b_valid)) gate_viol++;
        if (bus.a_ready) begin
          kb++;
          stall_left = (kb < k) ? stall_pat[kb] : 0;
        end else if (kb > 0 && stall_left > 0) begin
          stall_left--;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
      end
    end
    bus.a_valid = 1'b0; bus.b_valid = 1'b0; bus.a_data = '0; bus.b_data = '0;
    chk("arr_clear_pulses", clr_cnt, 1);
    chk("ready_gating", gate_viol, 0);
    if (lat < 0) begin
      chk("res_valid_timeout", bus.res_valid, 1'b1);
      for (int r = 0; r < N; r++) for (int j = 0; j < N; j++) got[r][j] = 16'hDEAD;
      return;
    end
    chk("edge_quiet_out", {bus.arr_a, bus.arr_b}, '0);
    for (int r = 0; r < N; r++) begin
      held = bus.res_data;
      for (int h = 0; h < hold; h++) begin
        bus.res_ready = 1'b0; bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (bus.res_data !== held || bus.res_valid !== 1'b1) stab_viol++;
      end
      bus.res_ready = 1'b1;
      bus.start = (hold > 0) && (r == N - 1);
      #1;
      for (int j = 0; j < N; j++) got[r][j] = bus.res_data[j*16 +: 16];
      chk($sformatf("res_last_row%0d", r), bus.res_last, (r == N - 1));
      @(posedge clk);
      @(negedge clk);
      bus.res_ready = 1'b0; bus.start = 1'b0;
    end
    chk("busy_after_job", bus.busy, 1'b0);
    chk("res_valid_after_job", bus.res_valid, 1'b0);
    chk("hold_stable", stab_viol, 0);
  endtask

  task automatic check_tab_rows(input string tag, input logic [1:0][31:0] c);
    for (int r = 0; r < N; r++)
      for (int j = 0; j < N; j++)
        chk($sformatf("%s_C%0d%0d", tag, r, j), got[r][j], c[r][j*16 +: 16]);
  endtask

  vec_t tab [5];

  initial begin
    int lat, k, hold, exp_lat;
    bus.start = 1'b0; bus.k_len = '0; bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    bus.a_data = '0; bus.b_data = '0; bus.res_ready = 1'b0;

    // K, stall before beat 1, res_ready hold, A cols, B rows, C rows, latency
    tab[0] = mk(1, 0, 0, 32'h0000_3838, 32'h0000_4038, 64'h4000_3F80_4000_3F80, 6);
    tab[1] = mk(2, 0, 0, 32'hB838_4038, 32'h3838_3840, 64'h3F80_4040_4000_4040, 7);
    tab[2] = mk(2, 3, 0, 32'hB838_4038, 32'h3838_3840, 64'h3F80_4040_4000_4040, 10);
    tab[3] = mk(0, 0, 0, 32'h4444_4444, 32'h4444_4444, 64'h0, 5);
    tab[4] = mk(1, 0, 5, 32'h0000_3838, 32'h0000_4038, 64'h4000_3F80_4000_3F80, 6);

    repeat (2) @(negedge clk);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_a_ready", bus.a_ready, 1'b0);
    chk("rst_arr_clear", bus.arr_clear, 1'b0);
    chk("rst_res_valid", bus.res_valid, 1'b0);
    chk("rst_res_last", bus.res_last, 1'b0);
    chk("rst_arr_a", bus.arr_a, '0);
    chk("rst_arr_b", bus.arr_b, '0);
    chk("rst_res_data", bus.res_data, '0);
    rst_n = 1'b1;

    for (int t = 0; t < 5; t++) begin
      load_vec(tab[t]);
      run_job(tab[t].k, tab[t].hold, lat);
      $display("vec %0d: K=%0d stall=%0d hold=%0d latency=%0d", t, tab[t].k, tab[t].stall, tab[t].hold, lat);
      chk($sformatf("vec%0d_latency", t), lat, tab[t].lat);
      check_tab_rows($sformatf("vec%0d", t), tab[t].c_row);
    end

    // Reset while operands are inside the skew lines.
    @(negedge clk); bus.start = 1'b1; bus.k_len = 8'd2;
    @(posedge clk);
    @(negedge clk); bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.a_valid = 1'b1; bus.b_valid = 1'b1; bus.a_data = 16'h4038; bus.b_data = 16'h4038;
    #1 chk("midjob_beat_ready", bus.a_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    bus.a_valid = 1'b0; bus.b_valid = 1'b0; bus.a_data = '0; bus.b_data = '0;
    #1;
    chk("midjob_arr_a_skew", bus.arr_a, 16'h4000);
    chk("midjob_arr_b_skew", bus.arr_b, 16'h4000);
    #2 rst_n = 1'b0;
    #1;
    $display("async reset asserted mid-FEED");
    chk("areset_busy", bus.busy, 1'b0);
    chk("areset_arr_a", bus.arr_a, '0);
    chk("areset_arr_b", bus.arr_b, '0);
    chk("areset_res_valid", bus.res_valid, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    load_vec(tab[0]);
    run_job(tab[0].k, 0, lat);
    $display("rerun after reset: K=1 latency=%0d", lat);
    chk("rerun_latency", lat, 6);
    check_tab_rows("rerun", tab[0].c_row);

    // Random jobs against the matrix-product reference.
    for (int t = 0; t < 10; t++) begin
      k = $urandom_range(0, 5);
      hold = $urandom_range(0, 2);
      exp_lat = k + 2 * N + 1;
      for (int kk = 0; kk < KMAX; kk++) begin
        stall_pat[kk] = (kk == 0) ? 0 : int'($urandom_range(0, 2));
        if (kk >= 1 && kk < k) exp_lat += stall_pat[kk];
        for (int i = 0; i < N; i++) a_mat[i][kk] = pool[$urandom_range(0, 6)];
        for (int j = 0; j < N; j++) b_mat[kk][j] = pool[$urandom_range(0, 6)];
      end
      run_job(k, hold, lat);
      $display("rand %0d: K=%0d hold=%0d latency=%0d expected=%0d", t, k, hold, lat, exp_lat);
      chk($sformatf("rand%0d_latency", t), lat, exp_lat);
      for (int r = 0; r < N; r++)
        for (int j = 0; j < N; j++)
          chk($sformatf("rand%0d_C%0d%0d", t, r, j), got[r][j], ref_c(r, j, k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
